// File: rtl/and_gate_sweep_checker_if.sv
// and_gate_sweep_checker_if: stimulus, sample and status signals between the sweep checker and its surroundings
interface and_gate_sweep_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             dut_y;
  logic             drv_a;
  logic             drv_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic             mismatch;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       vec_idx;
  modport master (
    input  start, dut_y,
    output drv_a, drv_b, busy, done, pass, mismatch, err_count, vec_idx
  );
  modport slave (
    output start, dut_y,
    input  drv_a, drv_b, busy, done, pass, mismatch, err_count, vec_idx
  );
endinterface

// File: rtl/and_gate_sweep_checker.sv
// and_gate_sweep_checker: sweeps all {a,b} vectors into an and_gate, checks y against a&b and reports a verdict
module and_gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 8
) (
  input logic clk,
  input logic rst,
  and_gate_sweep_checker_if.master bus
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t           r_state;
  logic [SW-1:0]    r_settle;
  logic [PW-1:0]    r_pass_cnt;
  logic [1:0]       r_vec;
  logic [CNT_W-1:0] r_err;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_mis;
  logic             w_fail;
  logic             w_last;
  logic [CNT_W-1:0] w_err_inc;
  // 4-state compare so an undriven or unknown y is flagged as a failure
  assign w_fail    = bus.dut_y !== (r_vec[1] & r_vec[0]);
  assign w_last    = (r_vec == 2'd3) && (r_pass_cnt == PW'(PASSES - 1));
  assign w_err_inc = &r_err ? r_err : r_err + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_settle   <= '0;
      r_pass_cnt <= '0;
      r_vec      <= '0;
      r_err      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_mis      <= 1'b0;
    end else begin
      r_mis <= 1'b0;
      case (r_state)
        IDLE, DONE: if (bus.start) begin
          r_state    <= SETTLE;
          r_settle   <= SW'(SETTLE_CYCLES);
          r_pass_cnt <= '0;
          r_vec      <= '0;
          r_err      <= '0;
          r_busy     <= 1'b1;
          r_done     <= 1'b0;
          r_pass     <= 1'b0;
        end
        SETTLE: if (r_settle == SW'(1)) r_state <= CHECK;
                else r_settle <= r_settle - 1'b1;
        default: begin
          r_mis    <= w_fail;
          r_err    <= w_fail ? w_err_inc : r_err;
          r_settle <= SW'(SETTLE_CYCLES);
          r_vec    <= w_last ? r_vec : r_vec + 2'd1;
          if (r_vec == 2'd3) r_pass_cnt <= r_pass_cnt + 1'b1;
          r_state  <= w_last ? DONE : SETTLE;
          r_busy   <= !w_last;
          r_done   <= w_last;
          r_pass   <= w_last && !w_fail && (r_err == '0);
        end
      endcase
    end
  end
  assign bus.drv_a     = r_vec[1];
  assign bus.drv_b     = r_vec[0];
  assign bus.vec_idx   = r_vec;
  assign bus.err_count = r_err;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.mismatch  = r_mis;
endmodule
